// File: rtl/btn_debounce_pkg.sv
// Shared constants and types for the button debouncer.
// Channel indices, default parameters and the per-channel FSM state.
package btn_debounce_pkg;

    localparam int BTN_A_IDX = 0;
    localparam int BTN_B_IDX = 1;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_GLITCH_W      = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: synchroniser, stability FSM, edge pulses.
// glitch is a same-cycle event flag consumed by the parent's counter.
module debounce_chan
    import btn_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic lvl,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;
    logic                   accept;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    end

    // Stability FSM: accept a new level only after it persists.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        accept  = 1'b0;
        glitch  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s != lvl_q) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (s == lvl_q) begin
                    glitch  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            lvl_d = s;
        end
        rise_d = accept & s;
        fall_d = accept & ~s;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with a saturating glitch counter.
// Bit 0 is channel a, bit 1 is channel b.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int N_BTN         = 2,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int GLITCH_W      = DEF_GLITCH_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_BTN-1:0]    btn_raw,
    output logic [N_BTN-1:0]    btn,
    output logic [N_BTN-1:0]    btn_rise,
    output logic [N_BTN-1:0]    btn_fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int SW = GLITCH_W + $clog2(N_BTN + 1);
    localparam logic [SW-1:0] SAT = SW'({GLITCH_W{1'b1}});

    logic [N_BTN-1:0]    glitch;
    logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;
    logic [SW-1:0]       sum;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[i]),
            .lvl   (btn[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i]),
            .glitch(glitch[i])
        );
    end

    // Add this cycle's glitch events and clamp at the counter maximum.
    always_comb begin
        sum = SW'(glitch_cnt_q);
        for (int i = 0; i < N_BTN; i++) begin
            sum = sum + SW'(glitch[i]);
        end
        if (sum > SAT) begin
            glitch_cnt_d = '1;
        end else begin
            glitch_cnt_d = sum[GLITCH_W-1:0];
        end
    end

    // Glitch counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce, default parameters.
// Inputs change 1ns after a rising edge; outputs sampled at the same point.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] btn;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic [7:0] glitch_cnt;

    int checks = 0;
    int errors = 0;

    btn_debounce u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn       (btn),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] raw);
        btn_raw = raw;
        reset   = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2'b00);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({btn, btn_rise, btn_fall, glitch_cnt} !== 14'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got btn=%b r=%b f=%b g=%0d want all 0",
                         i, btn, btn_rise, btn_fall, glitch_cnt);
            end
            tick();
        end
    endtask

    task automatic test_press_release();
        btn_raw = 2'b01;
        repeat (5) tick();
        checks++;
        if (btn !== 2'b00 || btn_rise !== 2'b00) begin
            errors++;
            $display("FAIL press_early got btn=%b r=%b want 00 00", btn, btn_rise);
        end
        tick();
        checks++;
        if (btn !== 2'b01 || btn_rise !== 2'b01) begin
            errors++;
            $display("FAIL press_edge6 got btn=%b r=%b want 01 01", btn, btn_rise);
        end
        tick();
        checks++;
        if (btn !== 2'b01 || btn_rise !== 2'b00) begin
            errors++;
            $display("FAIL press_after got btn=%b r=%b want 01 00", btn, btn_rise);
        end
        btn_raw = 2'b00;
        repeat (5) tick();
        checks++;
        if (btn !== 2'b01 || btn_fall !== 2'b00) begin
            errors++;
            $display("FAIL release_early got btn=%b f=%b want 01 00", btn, btn_fall);
        end
        tick();
        checks++;
        if (btn !== 2'b00 || btn_fall !== 2'b01) begin
            errors++;
            $display("FAIL release_edge6 got btn=%b f=%b want 00 01", btn, btn_fall);
        end
        tick();
        checks++;
        if (btn_fall !== 2'b00 || glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL release_after got f=%b g=%0d want 00 0", btn_fall, glitch_cnt);
        end
    endtask

    task automatic test_glitch();
        btn_raw = 2'b10;
        repeat (2) tick();
        btn_raw = 2'b00;
        repeat (2) tick();
        checks++;
        if (glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL glitch_before got g=%0d want 0", glitch_cnt);
        end
        tick();
        checks++;
        if (glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL glitch_count got g=%0d want 1", glitch_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({btn, btn_rise, btn_fall} !== 6'd0 || glitch_cnt !== 8'd1) begin
                errors++;
                $display("FAIL glitch_quiet cyc=%0d got btn=%b r=%b f=%b g=%0d want 0 0 0 1",
                         i, btn, btn_rise, btn_fall, glitch_cnt);
            end
            tick();
        end
    endtask

    task automatic test_reset_pending();
        btn_raw = 2'b01;
        repeat (4) tick();
        checks++;
        if (u_dut.g_chan[0].u_chan.cnt_q !== 2'd2) begin
            errors++;
            $display("FAIL pend_cnt got cnt=%0d want 2", u_dut.g_chan[0].u_chan.cnt_q);
        end
        btn_raw = 2'b00;
        reset   = 1'b1;
        tick();
        checks++;
        if (u_dut.g_chan[0].u_chan.cnt_q !== 2'd0 || btn !== 2'b00 ||
            btn_rise !== 2'b00 || glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL pend_reset got cnt=%0d btn=%b r=%b g=%0d want 0 00 00 0",
                     u_dut.g_chan[0].u_chan.cnt_q, btn, btn_rise, glitch_cnt);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({btn, btn_rise, btn_fall, glitch_cnt} !== 14'd0) begin
                errors++;
                $display("FAIL pend_quiet cyc=%0d got btn=%b r=%b f=%b g=%0d want all 0",
                         i, btn, btn_rise, btn_fall, glitch_cnt);
            end
        end
    endtask

    task automatic test_held_through_reset();
        do_reset(2'b11);
        repeat (5) tick();
        checks++;
        if (btn !== 2'b00) begin
            errors++;
            $display("FAIL held_early got btn=%b want 00", btn);
        end
        tick();
        checks++;
        if (btn !== 2'b11 || btn_rise !== 2'b11) begin
            errors++;
            $display("FAIL held_rise got btn=%b r=%b want 11 11", btn, btn_rise);
        end
        tick();
        checks++;
        if (btn_rise !== 2'b00 || glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL held_after got r=%b g=%0d want 00 0", btn_rise, glitch_cnt);
        end
    endtask

    task automatic test_bouncy();
        logic [4:0] pat;
        int ra, rb, na, nb;
        pat = 5'b10101;
        ra = -1; rb = -1; na = 0; nb = 0;
        do_reset(2'b00);
        for (int c = 0; c < 30; c++) begin
            logic [1:0] nxt;
            nxt[0] = (c < 5) ? pat[c] : 1'b1;
            nxt[1] = (c >= 10);
            btn_raw = nxt;
            tick();
            if (btn_rise[0]) begin na++; ra = c; end
            if (btn_rise[1]) begin nb++; rb = c; end
        end
        checks++;
        if (na !== 1 || ra !== 9) begin
            errors++;
            $display("FAIL bouncy_a got n=%0d at=%0d want 1 at 9", na, ra);
        end
        checks++;
        if (nb !== 1 || rb !== 15) begin
            errors++;
            $display("FAIL bouncy_b got n=%0d at=%0d want 1 at 15", nb, rb);
        end
        checks++;
        if (btn !== 2'b11 || glitch_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bouncy_end got btn=%b g=%0d want 11 2", btn, glitch_cnt);
        end
    endtask

    task automatic test_dual_saturate();
        do_reset(2'b00);
        btn_raw = 2'b11;
        repeat (2) tick();
        btn_raw = 2'b00;
        repeat (2) tick();
        checks++;
        if (glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL dual_before got g=%0d want 0", glitch_cnt);
        end
        tick();
        checks++;
        if (glitch_cnt !== 8'd2) begin
            errors++;
            $display("FAIL dual_plus2 got g=%0d want 2", glitch_cnt);
        end
        tick();
        for (int p = 1; p < 200; p++) begin
            btn_raw = 2'b11;
            repeat (2) tick();
            btn_raw = 2'b00;
            repeat (4) tick();
            if (p == 126) begin
                checks++;
                if (glitch_cnt !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_254 got g=%0d want 254", glitch_cnt);
                end
            end
            if (p == 127) begin
                checks++;
                if (glitch_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_clamp got g=%0d want 255", glitch_cnt);
                end
            end
        end
        checks++;
        if (glitch_cnt !== 8'd255 || btn !== 2'b00) begin
            errors++;
            $display("FAIL sat_200 got g=%0d btn=%b want 255 00", glitch_cnt, btn);
        end
        repeat (10) tick();
        checks++;
        if (glitch_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold got g=%0d want 255", glitch_cnt);
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 2'b00;
        test_reset();
        test_press_release();
        test_glitch();
        do_reset(2'b00);
        test_reset_pending();
        test_held_through_reset();
        test_bouncy();
        test_dual_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
